// File: rtl/mux_sweep_pkg.sv
// Shared types and helpers for the mux sweep/capture block.
package mux_sweep_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int VOTE_N = 3;

   function automatic int cnt_width(input int settle);
      return $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/maj3_vote.sv
// Combinational 2-of-3 majority vote over repeated samples of one mux input.
module maj3_vote (
   input  logic [2:0] bits,
   output logic       vote
);

   assign vote = (bits[0] & bits[1]) | (bits[0] & bits[2]) | (bits[1] & bits[2]);

endmodule

// File: rtl/mux_sweep_capture.sv
// Sweeps an 8:1 mux select, samples each settled output bit and returns the word with valid/ready.
// MUX_SWEEP_MAJORITY_EN: take 3 samples per select and keep their majority.
module mux_sweep_capture
   import mux_sweep_pkg::*;
#(
   parameter int SEL_W  = 3,
   parameter int NUM_IN = 8,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mux_out,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic [NUM_IN-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready
);

   localparam int CNT_W = cnt_width(SETTLE);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sample_bit;
   logic             last_sample;

`ifdef MUX_SWEEP_MAJORITY_EN
   // Older samples of the current select; the newest comes straight from mux_out.
   logic [VOTE_N-2:0] shreg;
   logic [1:0]        vcnt;

   maj3_vote u_vote (
      .bits ({shreg, mux_out}),
      .vote (sample_bit)
   );

   assign last_sample = (vcnt == 2'(VOTE_N - 1));
`else
   assign sample_bit  = mux_out;
   assign last_sample = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         sel        <= '0;
         busy       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
`ifdef MUX_SWEEP_MAJORITY_EN
         shreg      <= '0;
         vcnt       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               sel <= '0;
               if (start) begin
                  dout  <= '0;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == CNT_W'(SETTLE - 1)) begin
                  cnt   <= '0;
                  state <= S_SAMPLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_SAMPLE: begin
`ifdef MUX_SWEEP_MAJORITY_EN
               shreg <= {shreg[VOTE_N-3:0], mux_out};
               vcnt  <= last_sample ? 2'd0 : vcnt + 2'd1;
`endif
               if (last_sample) begin
                  dout[sel] <= sample_bit;
                  if (sel == SEL_W'(NUM_IN - 1)) begin
                     busy       <= 1'b0;
                     dout_valid <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     sel   <= sel + SEL_W'(1);
                     cnt   <= '0;
                     state <= S_SETTLE;
                  end
               end
            end
            S_DONE: begin
               // start is deliberately not looked at here; requester retries in IDLE.
               if (dout_ready) begin
                  dout_valid <= 1'b0;
                  sel        <= '0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_sweep_capture.sv
// Directed bench: 8:1 mux model feeding mux_sweep_capture, checks timing and captured words.
module tb_mux_sweep_capture;

   localparam int SEL_W  = 3;
   localparam int NUM_IN = 8;
   localparam int SETTLE = 2;
`ifdef MUX_SWEEP_MAJORITY_EN
   localparam int PER = SETTLE + 3;
`else
   localparam int PER = SETTLE + 1;
`endif
   localparam int LAT = NUM_IN * PER;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              mux_out;
   logic [SEL_W-1:0]  sel;
   logic              busy;
   logic [NUM_IN-1:0] dout;
   logic              dout_valid;
   logic              dout_ready = 1'b0;
   logic [NUM_IN-1:0] mux_in = '0;

   int n_cmp = 0;
   int n_err = 0;

   assign mux_out = mux_in[sel];

   always #5 clk = ~clk;

   mux_sweep_capture #(.SEL_W(SEL_W), .NUM_IN(NUM_IN), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mux_out    (mux_out),
      .sel        (sel),
      .busy       (busy),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_sel", 32'(sel), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_valid", 32'(dout_valid), 0);
      rst_n = 1'b1;
      tick();

      // 1: full sweep of 8'hA5, select stepping and exact latency
      mux_in = 8'hA5;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_busy_acc", 32'(busy), 1);
      chk("t1_sel_acc", 32'(sel), 0);
      for (int k = 1; k < LAT; k++) begin
         tick();
         chk("t1_sel", 32'(sel), 32'(k / PER));
         chk("t1_novalid", 32'(dout_valid), 0);
         chk("t1_busy", 32'(busy), 1);
      end
      tick();
      chk("t1_valid", 32'(dout_valid), 1);
      chk("t1_dout", 32'(dout), 32'h A5);
      chk("t1_busy_done", 32'(busy), 0);
      chk("t1_sel_done", 32'(sel), 7);

      // 2: hold in DONE while not ready, then hand off
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t2_hold_valid", 32'(dout_valid), 1);
         chk("t2_hold_dout", 32'(dout), 32'h A5);
      end
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("t2_valid_drop", 32'(dout_valid), 0);
      chk("t2_sel_idle", 32'(sel), 0);
      chk("t2_busy_idle", 32'(busy), 0);
      chk("t2_dout_kept", 32'(dout), 32'h A5);

      // 3: start pulse in SETTLE at sel 3 is ignored
      mux_in = 8'h5A;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         start = (k == 3 * PER + 1);
         if (k < LAT) begin
            chk("t3_sel", 32'(sel), 32'(k / PER));
            chk("t3_novalid", 32'(dout_valid), 0);
         end
      end
      chk("t3_valid", 32'(dout_valid), 1);
      chk("t3_dout", 32'(dout), 32'h 5A);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("t3_valid_drop", 32'(dout_valid), 0);

      // 4: reset mid-sweep at sel 5 discards the word
      mux_in = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 5 * PER + 1; k++) tick();
      chk("t4_sel_pre", 32'(sel), 5);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t4_sel", 32'(sel), 0);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_dout", 32'(dout), 0);
      chk("t4_valid", 32'(dout_valid), 0);
      for (int k = 0; k < LAT + 4; k++) begin
         tick();
         chk("t4_quiet", 32'({busy, dout_valid}), 0);
      end
      mux_in = 8'h96;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_restart_sel", 32'(sel), 0);
      chk("t4_restart_busy", 32'(busy), 1);
      for (int k = 1; k < LAT; k++) tick();
      chk("t4_early", 32'(dout_valid), 0);
      tick();
      chk("t4_valid2", 32'(dout_valid), 1);
      chk("t4_dout2", 32'(dout), 32'h 96);

      // 5: start with ready in DONE is dropped; start next cycle is taken
      start = 1'b1;
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("t5_valid", 32'(dout_valid), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_sel", 32'(sel), 0);
      chk("t5_dout", 32'(dout), 32'h 96);
      mux_in = 8'h0F;
      tick();
      start = 1'b0;
      chk("t5_accept", 32'(busy), 1);
      chk("t5_cleared", 32'(dout), 0);
      for (int k = 1; k < LAT; k++) tick();
      chk("t5_early", 32'(dout_valid), 0);
      tick();
      chk("t5_valid2", 32'(dout_valid), 1);
      chk("t5_dout2", 32'(dout), 32'h 0F);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;

`ifdef MUX_SWEEP_MAJORITY_EN
      // 6: in[2] changes between its three samples (edges 2*PER+3..2*PER+5)
      for (int run = 0; run < 2; run++) begin
         mux_in = (run == 0) ? 8'h3C : 8'h38;
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 2 * PER + 3) mux_in[2] = (run == 0) ? 1'b0 : 1'b1;
            if (k == 2 * PER + 4) mux_in[2] = (run == 0) ? 1'b1 : 1'b0;
            if (k < LAT) chk("t6_novalid", 32'(dout_valid), 0);
         end
         chk("t6_valid", 32'(dout_valid), 1);
         chk("t6_dout", 32'(dout), (run == 0) ? 32'h 3C : 32'h 38);
         dout_ready = 1'b1;
         tick();
         dout_ready = 1'b0;
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
